register_file_writer: RTL and testbench

REGISTER_FILE_WRITER -- requirements
Module: register_file_writer

---
 rtl/register_file_writer.sv | 119 +++++++++++
 tb/tb_register_file_writer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_writer.sv
// Queued write port for an 8x16 register file: buffers requests, drains them in order, reports pending hazards.
// Optional forwarding of the newest pending data is enabled by defining REGISTER_FILE_WRITER_FORWARD_EN.
module register_file_writer #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [2:0]               in_addr,
  input  logic                     drain_en,
  output logic [WIDTH-1:0]         D,
  output logic [2:0]               DA,
  output logic                     W,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [2:0]               hz_addr,
  output logic                     hz_pending,
  output logic                     fwd_hit,
  output logic [WIDTH-1:0]         fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem_data [DEPTH];
  logic [2:0]       r_mem_addr [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_d;
  logic [2:0]       r_da;
  logic             r_w;

  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;

  // A full queue refuses pushes even when a pop happens on the same edge.
  assign in_ready = (r_count < FULL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_count != '0) && drain_en;

  assign D     = r_d;
  assign DA    = r_da;
  assign W     = r_w;
  assign count = r_count;

  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_addr[r_wr_ptr] <= in_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_d      <= '0;
      r_da     <= '0;
      r_w      <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_d      <= r_mem_data[r_rd_ptr];
        r_da     <= r_mem_addr[r_rd_ptr];
        r_w      <= 1'b1;
      end else begin
        r_w      <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] w_off;
      assign w_off       = AW'(gi) - r_rd_ptr;
      assign w_match[gi] = ({1'b0, w_off} < r_count) && (r_mem_addr[gi] == hz_addr);
    end
  endgenerate

  assign hz_pending = (|w_match) || (r_w && (r_da == hz_addr));

`ifdef REGISTER_FILE_WRITER_FORWARD_EN
  logic [WIDTH-1:0] w_fwd_data;

  // Walk oldest to newest so the youngest matching entry wins.
  always_comb begin
    w_fwd_data = '0;
    if (r_w && (r_da == hz_addr)) begin
      w_fwd_data = r_d;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[r_rd_ptr + AW'(k)]) begin
        w_fwd_data = r_mem_data[r_rd_ptr + AW'(k)];
      end
    end
  end

  assign fwd_hit  = hz_pending;
  assign fwd_data = w_fwd_data;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_register_file_writer.sv
// Bench for register_file_writer: directed scenarios plus random traffic, scored against a queue-based model.
module tb_register_file_writer;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_addr;
  logic             drain_en;
  logic [WIDTH-1:0] D;
  logic [2:0]       DA;
  logic             W;
  logic [2:0]       count;
  logic [2:0]       hz_addr;
  logic             hz_pending;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic [2:0]       a;
    logic [WIDTH-1:0] d;
  } ent_t;

  ent_t             mq[$];
  ent_t             exp_q[$];
  logic             m_w;
  logic [2:0]       m_da;
  logic [WIDTH-1:0] m_d;

  register_file_writer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_addr    (in_addr),
    .drain_en   (drain_en),
    .D          (D),
    .DA         (DA),
    .W          (W),
    .count      (count),
    .hz_addr    (hz_addr),
    .hz_pending (hz_pending),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; pops happen before pushes so a fresh entry never drains on its push edge.
  initial begin
    ent_t e;
    bit   push_ok;
    m_w = 1'b0; m_da = '0; m_d = '0;
    forever begin
      @(posedge clock);
      if (!reset) begin
        mq.delete();
        m_w = 1'b0; m_da = '0; m_d = '0;
      end else begin
        push_ok = in_valid && (mq.size() < DEPTH);
        if (drain_en && mq.size() > 0) begin
          e = mq.pop_front();
          m_w = 1'b1; m_da = e.a; m_d = e.d;
          exp_q.push_back(e);
        end else begin
          m_w = 1'b0;
        end
        if (push_ok) begin
          e = {in_addr, in_data};
          mq.push_back(e);
        end
      end
    end
  end

  function automatic void model_hz(output bit pend, output logic [WIDTH-1:0] fd);
    pend = 1'b0;
    fd   = '0;
    if (m_w && m_da == hz_addr) begin
      pend = 1'b1;
      fd   = m_d;
    end
    foreach (mq[i]) begin
      if (mq[i].a == hz_addr) begin
        pend = 1'b1;
        fd   = mq[i].d;
      end
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a write.
  initial begin
    ent_t             e;
    bit               p;
    logic [WIDTH-1:0] fd;
    forever begin
      @(posedge clock);
      #1;
      chk("W", W, m_w);
      if (W === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL write: unexpected W=1 DA=%0d D=%h with nothing expected at %0t", DA, D, $time);
        end else begin
          e = exp_q.pop_front();
          $display("write DA=%0d D=%h (expected DA=%0d D=%h)", DA, D, e.a, e.d);
          chk("DA", DA, e.a);
          chk("D", D, e.d);
        end
      end
      chk("D_hold", D, m_d);
      chk("DA_hold", DA, m_da);
      chk("count", count, mq.size());
      chk("in_ready", in_ready, mq.size() < DEPTH);
      model_hz(p, fd);
      chk("hz_pending", hz_pending, p);
`ifdef REGISTER_FILE_WRITER_FORWARD_EN
      chk("fwd_hit", fwd_hit, p);
      chk("fwd_data", fwd_data, fd);
`else
      chk("fwd_hit", fwd_hit, 0);
      chk("fwd_data", fwd_data, 0);
`endif
    end
  end

  // Drive one cycle from a falling edge; acc reports whether the request is taken at the next rising edge.
  task automatic step(input bit v, input logic [2:0] a, input logic [WIDTH-1:0] d,
                      input bit de, output bit acc);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    drain_en = de;
    acc      = v && in_ready && reset;
    @(negedge clock);
  endtask

  initial begin
    bit               acc;
    bit               done;
    bit               v;
    bit               pend;
    bit               de;
    logic [2:0]       a;
    logic [WIDTH-1:0] d;

    reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0; drain_en = 1'b0; hz_addr = '0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_count", count, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_W", W, 0);
    chk("rst_D", D, 0);
    chk("rst_DA", DA, 0);
    reset = 1'b1;

    // Single write: W high in the cycle after the second edge.
    step(1'b1, 3'd3, 16'h1234, 1'b1, acc);
    chk("first_accept", acc, 1);
    step(1'b0, 3'd0, 16'h0, 1'b1, acc);
    chk("single_W", W, 1);
    chk("single_DA", DA, 3);
    chk("single_D", D, 16'h1234);
    step(1'b0, 3'd0, 16'h0, 1'b1, acc);
    chk("single_W_off", W, 0);

    // Fill with drain off; fifth request held until space opens.
    for (int i = 0; i < 4; i++) step(1'b1, 3'(i + 1), 16'h5000 + 16'(i), 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd6, 16'h5555, 1'b0, acc);
      chk("full_refuse", acc, 0);
    end
    chk("full_count", count, 4);
    chk("full_ready", in_ready, 0);
    done = 1'b0;
    for (int t = 0; t < 10 && !done; t++) begin
      step(1'b1, 3'd6, 16'h5555, 1'b1, acc);
      done = acc;
    end
    chk("fifth_accepted", done, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 3'd0, 16'h0, 1'b1, acc);

    // Two pending writes to the same register.
    hz_addr = 3'd2;
    step(1'b1, 3'd2, 16'hAAAA, 1'b0, acc);
    step(1'b1, 3'd2, 16'hBBBB, 1'b0, acc);
    step(1'b0, 3'd0, 16'h0, 1'b0, acc);
    chk("hz_same_reg", hz_pending, 1);
`ifdef REGISTER_FILE_WRITER_FORWARD_EN
    chk("fwd_newest_hit", fwd_hit, 1);
    chk("fwd_newest_data", fwd_data, 16'hBBBB);
`else
    chk("fwd_off_hit", fwd_hit, 0);
    chk("fwd_off_data", fwd_data, 0);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0, 1'b1, acc);

    // Steady push and pop at count 2 across pointer wrap.
    step(1'b1, 3'd0, 16'h0F00, 1'b0, acc);
    step(1'b1, 3'd7, 16'h0F01, 1'b0, acc);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 1'b1, acc);
      chk("stream_accept", acc, 1);
      chk("stream_count", count, 2);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 3'd0, 16'h0, 1'b1, acc);

    // Reset with three queued entries and a write in flight.
    hz_addr = 3'd5;
    for (int i = 0; i < 4; i++) step(1'b1, 3'd5, 16'hC000 + 16'(i), 1'b0, acc);
    step(1'b0, 3'd0, 16'h0, 1'b1, acc);
    chk("pre_rst_count", count, 3);
    chk("pre_rst_W", W, 1);
    reset = 1'b0;
    step(1'b1, 3'd5, 16'hDEAD, 1'b1, acc);
    chk("mid_rst_W", W, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_hz", hz_pending, 0);
    reset = 1'b1;

    // Random traffic; a refused request is held unchanged until taken.
    pend = 1'b0; v = 1'b0; a = '0; d = '0;
    for (int i = 0; i < 400; i++) begin
      hz_addr = 3'($urandom_range(0, 7));
      de      = ($urandom_range(0, 9) < 5);
      reset   = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      if (!pend) begin
        v = ($urandom_range(0, 2) != 0);
        a = 3'($urandom_range(0, 7));
        d = 16'($urandom);
      end
      step(v, a, d, de, acc);
      pend = v && !acc;
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 3'd0, 16'h0, 1'b1, acc);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
